// File: rtl/display_pkg.sv
// Shared types for the two-requester display arbiter.
// Holds the FSM state encoding and requester index constants.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    typedef logic idx_t;

    localparam idx_t REQ_A = 1'b0;
    localparam idx_t REQ_B = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: clears on ownership entry, counts ticks,
// saturates at DWELL and flags done once saturated.
module dwell_timer #(
    parameter int DWELL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        tick,
    output logic [15:0] count,
    output logic        done
);

    localparam logic [15:0] LIMIT = 16'(DWELL);

    assign done = (count == LIMIT);

    // clear wins over tick; counting stops at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !done) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates two digit sources onto one seven-segment display.
// Round-robin on ties, dwell-based preemption, registered data path.
module display_arbiter
    import display_pkg::*;
#(
    parameter int DWELL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [1:0]  req,
    input  logic [15:0] digits_a,
    input  logic [3:0]  points_a,
    input  logic [15:0] digits_b,
    input  logic [3:0]  points_b,
    output logic [1:0]  gnt,
    output logic [15:0] digits,
    output logic [3:0]  decimal_points,
    output logic        blank
);

    state_t      state;
    state_t      state_nxt;
    idx_t        rr;
    logic        entry;
    logic [15:0] dwell_cnt;
    logic        dwell_done;
    logic [15:0] digits_q;
    logic [3:0]  points_q;

    // next owner: tie-break, owner drop-out and preemption
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   state_nxt = OWN_A;
                    2'b10:   state_nxt = OWN_B;
                    2'b11:   state_nxt = (rr == REQ_B) ?
                                         OWN_A : OWN_B;
                    default: state_nxt = IDLE;
                endcase
            end
            OWN_A: begin
                if (!req[REQ_A]) begin
                    state_nxt = req[REQ_B] ? OWN_B : IDLE;
                end else if (dwell_done && req[REQ_B]) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_B: begin
                if (!req[REQ_B]) begin
                    state_nxt = req[REQ_A] ? OWN_A : IDLE;
                end else if (dwell_done && req[REQ_A]) begin
                    state_nxt = OWN_A;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign entry = (state_nxt != IDLE) &&
                   (state_nxt != state);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (entry),
        .tick  (tick && (state != IDLE)),
        .count (dwell_cnt),
        .done  (dwell_done)
    );

    // state and round-robin pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr    <= REQ_B;
        end else begin
            state <= state_nxt;
            if (entry) begin
                rr <= (state_nxt == OWN_B) ? REQ_B : REQ_A;
            end
        end
    end

    // capture the incoming owner's data alongside its grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            points_q <= '0;
        end else begin
            unique case (state_nxt)
                OWN_A: begin
                    digits_q <= digits_a;
                    points_q <= points_a;
                end
                OWN_B: begin
                    digits_q <= digits_b;
                    points_q <= points_b;
                end
                default: begin
                    digits_q <= '0;
                    points_q <= '0;
                end
            endcase
        end
    end

    assign gnt            = state;
    assign blank          = (state == IDLE);
    assign digits         = digits_q;
    assign decimal_points = points_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: vector table, corner sequences,
// and randomized traffic against an ownership-level model.
module tb_display_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [1:0]  req;
    logic [15:0] digits_a;
    logic [3:0]  points_a;
    logic [15:0] digits_b;
    logic [3:0]  points_b;
    logic [1:0]  gnt;
    logic [15:0] digits;
    logic [3:0]  decimal_points;
    logic        blank;

    int n_pass = 0;
    int n_total = 0;

    display_arbiter #(
        .DWELL (DWELL)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .req            (req),
        .digits_a       (digits_a),
        .points_a       (points_a),
        .digits_b       (digits_b),
        .points_b       (points_b),
        .gnt            (gnt),
        .digits         (digits),
        .decimal_points (decimal_points),
        .blank          (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        tick;
        logic [15:0] da;
        logic [3:0]  pa;
        logic [15:0] db;
        logic [3:0]  pb;
        logic [1:0]  gnt;
        logic [15:0] dig;
        logic [3:0]  pts;
        logic        blank;
    } vec_t;

    vec_t tbl[$];

    // model state: owner -1 none, 0 A, 1 B
    int m_owner;
    int m_last;
    int m_dwell;
    logic [15:0] m_dig;
    logic [3:0]  m_pts;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick = 1'b0;
        req = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_owner = -1;
        m_last = 1;
        m_dwell = 0;
        m_dig = '0;
        m_pts = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ownership rules applied to inputs seen before the edge
    task automatic model_step();
        int nw;
        int oth;
        nw = m_owner;
        if (m_owner < 0) begin
            if (req == 2'b11) nw = 1 - m_last;
            else if (req == 2'b01) nw = 0;
            else if (req == 2'b10) nw = 1;
        end else begin
            oth = 1 - m_owner;
            if (!req[m_owner]) begin
                nw = req[oth] ? oth : -1;
            end else if (m_dwell == DWELL && req[oth]) begin
                nw = oth;
            end
        end
        if (nw >= 0 && nw != m_owner) begin
            m_dwell = 0;
            m_last = nw;
        end else if (m_owner >= 0 && tick &&
                     m_dwell < DWELL) begin
            m_dwell++;
        end
        m_owner = nw;
        if (nw == 0) begin
            m_dig = digits_a;
            m_pts = points_a;
        end else if (nw == 1) begin
            m_dig = digits_b;
            m_pts = points_b;
        end else begin
            m_dig = '0;
            m_pts = '0;
        end
    endtask

    function automatic logic [1:0] owner_gnt(int o);
        if (o == 0) return 2'b01;
        if (o == 1) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        req = 2'b00;
        digits_a = 16'h1234;
        points_a = 4'b0001;
        digits_b = 16'hABCD;
        points_b = 4'b1000;

        #2;
        chk("async_reset_gnt", 32'(gnt), 32'h0);
        chk("async_reset_blank", 32'(blank), 32'h1);
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_points", 32'(decimal_points), 32'h0);
        chk("reset_blank", 32'(blank), 32'h1);
        chk("reset_dwell", 32'(u_dut.dwell_cnt), 32'h0);

        // req tick da pa db pb | gnt dig pts blank
        tbl.push_back('{2'b00, 1'b1, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b00, 16'h0000, 4'h0, 1'b1});
        tbl.push_back('{2'b11, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 16'h5678, 4'h3,
            16'hABCD, 4'h8, 2'b01, 16'h5678, 4'h3, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b11, 1'b1, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b10, 16'hABCD, 4'h8, 1'b0});
        tbl.push_back('{2'b10, 1'b0, 16'h1234, 4'h1,
            16'h9E0F, 4'h6, 2'b10, 16'h9E0F, 4'h6, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b00, 16'h0000, 4'h0, 1'b1});
        tbl.push_back('{2'b11, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b10, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b10, 16'hABCD, 4'h8, 1'b0});
        tbl.push_back('{2'b01, 1'b0, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b01, 16'h1234, 4'h1, 1'b0});
        tbl.push_back('{2'b00, 1'b1, 16'h1234, 4'h1,
            16'hABCD, 4'h8, 2'b00, 16'h0000, 4'h0, 1'b1});

        foreach (tbl[i]) begin
            req = tbl[i].req;
            tick = tbl[i].tick;
            digits_a = tbl[i].da;
            points_a = tbl[i].pa;
            digits_b = tbl[i].db;
            points_b = tbl[i].pb;
            step();
            chk($sformatf("vec%0d_gnt", i),
                32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_digits", i),
                32'(digits), 32'(tbl[i].dig));
            chk($sformatf("vec%0d_points", i),
                32'(decimal_points), 32'(tbl[i].pts));
            chk($sformatf("vec%0d_blank", i),
                32'(blank), 32'(tbl[i].blank));
        end
        tick = 1'b0;

        // sole requester keeps the display; counter saturates
        do_reset();
        req = 2'b01;
        step();
        chk("sat_entry_gnt", 32'(gnt), 32'h1);
        tick = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("sat_gnt_%0d", i), 32'(gnt), 32'h1);
            chk($sformatf("sat_cnt_%0d", i),
                32'(u_dut.dwell_cnt),
                32'((i < DWELL) ? i : DWELL));
        end
        tick = 1'b0;

        // owner drops mid-dwell: direct handover, counter cleared
        do_reset();
        req = 2'b01;
        step();
        req = 2'b11;
        tick = 1'b1;
        step();
        step();
        chk("drop_pre_gnt", 32'(gnt), 32'h1);
        chk("drop_pre_cnt", 32'(u_dut.dwell_cnt), 32'd2);
        req = 2'b10;
        tick = 1'b0;
        @(negedge clk);
        chk("drop_hold_gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        chk("drop_no_idle", 32'(blank), 32'h0);
        #1;
        chk("drop_gnt", 32'(gnt), 32'h2);
        chk("drop_cnt", 32'(u_dut.dwell_cnt), 32'd0);
        chk("drop_digits", 32'(digits), 32'(digits_b));

        // reset between edges releases the grant at once
        do_reset();
        req = 2'b10;
        step();
        chk("mid_pre_gnt", 32'(gnt), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_gnt", 32'(gnt), 32'h0);
        chk("mid_reset_blank", 32'(blank), 32'h1);
        chk("mid_reset_digits", 32'(digits), 32'h0);
        step();

        // randomized traffic against the ownership model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 2'($urandom_range(0, 3));
            end
            tick = ($urandom_range(0, 2) == 0);
            digits_a = 16'($urandom);
            points_a = 4'($urandom);
            digits_b = 16'($urandom);
            points_b = 4'($urandom);
            model_step();
            step();
            chk($sformatf("rnd%0d_gnt", c),
                32'(gnt), 32'(owner_gnt(m_owner)));
            chk($sformatf("rnd%0d_digits", c),
                32'(digits), 32'(m_dig));
            chk($sformatf("rnd%0d_points", c),
                32'(decimal_points), 32'(m_pts));
            chk($sformatf("rnd%0d_blank", c),
                32'(blank), 32'(m_owner < 0));
            if (m_owner >= 0) begin
                chk($sformatf("rnd%0d_dwell", c),
                    32'(u_dut.dwell_cnt), 32'(m_dwell));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
